// File: rtl/wavelet_tap_window_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wavelet_tap_window_pkg
// Description : Constants and types shared by the wavelet FIR bank and its
//               tap-window feeders.
// Revision    : 1.0 - initial release
// ============================================================================
package wavelet_tap_window_pkg;

    localparam int c_bits_per_elem = 8;
    localparam int c_num_elem      = 7;

    typedef logic signed [c_bits_per_elem-1:0] tap_elem_t;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        RUN  = 1'b1
    } tap_win_state_t;

endpackage : wavelet_tap_window_pkg
`default_nettype wire

// File: rtl/wavelet_tap_window.sv
`default_nettype none
// ============================================================================
// Module      : wavelet_tap_window
// Description : Sliding sample window feeding one wavelet FIR, with a
//               registered start pulse once full and every STRIDE accepts.
// Revision    : 1.0 - initial release
// ============================================================================
module wavelet_tap_window
    import wavelet_tap_window_pkg::*;
#(
    parameter int BITS_PER_ELEM = c_bits_per_elem,
    parameter int NUM_ELEM      = c_num_elem,
    parameter int STRIDE        = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_sample_valid,
    input  logic signed [BITS_PER_ELEM-1:0]   i_sample,
    output logic                              o_sample_ready,
    input  logic                              i_flush,
    output logic [NUM_ELEM*BITS_PER_ELEM-1:0] o_taps,
    output logic                              o_start_calc,
    output logic [$clog2(NUM_ELEM+1)-1:0]     o_fill
);

    localparam int c_taps_w = NUM_ELEM * BITS_PER_ELEM;
    localparam int c_fill_w = $clog2(NUM_ELEM + 1);
    localparam int c_cnt_w  = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    localparam logic [c_fill_w-1:0] c_fill_last = c_fill_w'(NUM_ELEM - 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_last  = c_cnt_w'(STRIDE - 1);

    tap_win_state_t         r_state;
    tap_win_state_t         w_state_next;
    logic [c_fill_w-1:0]    r_fill;
    logic [c_fill_w-1:0]    w_fill_next;
    logic [c_cnt_w-1:0]     r_stride_cnt;
    logic [c_cnt_w-1:0]     w_stride_cnt_next;
    logic                   w_pulse_next;
    logic                   r_start_calc;
    logic [c_taps_w-1:0]    r_taps;
    logic                   w_accept;

    // Backpressure only during reset and flush; flush wins over a valid sample.
    assign o_sample_ready = ~rst & ~i_flush;
    assign w_accept       = i_sample_valid & o_sample_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_taps <= '0;
        end else if (i_flush) begin
            r_taps <= '0;
        end else if (w_accept) begin
            r_taps <= {r_taps[c_taps_w-BITS_PER_ELEM-1:0], i_sample};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= FILL;
            r_fill       <= '0;
            r_stride_cnt <= '0;
            r_start_calc <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_fill       <= w_fill_next;
            r_stride_cnt <= w_stride_cnt_next;
            r_start_calc <= w_pulse_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_fill_next       = r_fill;
        w_stride_cnt_next = r_stride_cnt;
        w_pulse_next      = 1'b0;
        if (i_flush) begin
            w_state_next      = FILL;
            w_fill_next       = '0;
            w_stride_cnt_next = '0;
        end else if (w_accept) begin
            case (r_state)
                FILL: begin
                    w_fill_next = r_fill + 1'b1;
                    if (r_fill == c_fill_last) begin
                        w_state_next      = RUN;
                        w_stride_cnt_next = '0;
                        w_pulse_next      = 1'b1;
                    end
                end
                RUN: begin
                    if (r_stride_cnt == c_cnt_last) begin
                        w_stride_cnt_next = '0;
                        w_pulse_next      = 1'b1;
                    end else begin
                        w_stride_cnt_next = r_stride_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_next = FILL;
                end
            endcase
        end
    end

    assign o_taps       = r_taps;
    assign o_start_calc = r_start_calc;
    assign o_fill       = r_fill;

endmodule : wavelet_tap_window
`default_nettype wire

// File: tb/tb_wavelet_tap_window.sv
`default_nettype none
// ============================================================================
// Module      : tb_wavelet_tap_window
// Description : Scoreboard bench for wavelet_tap_window, STRIDE=1 and STRIDE=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wavelet_tap_window;

    localparam int BW = 8;
    localparam int NE = 7;
    localparam int TW = NE * BW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sample_valid = 1'b0;
    logic [BW-1:0] sample = '0;
    logic          flush = 1'b0;

    logic          ready [2];
    logic [TW-1:0] taps  [2];
    logic          start [2];
    logic [2:0]    fill  [2];

    int n_checks = 0;
    int n_fail   = 0;

    logic [TW-1:0] m_win   [2];
    int            m_fill  [2];
    int            m_cnt   [2];
    logic          m_pulse [2];
    logic [TW-1:0] q0 [$];
    logic [TW-1:0] q1 [$];
    logic [TW-1:0] last_taps [2];
    int            n_pulse [2];
    int            fir_sum = 0;
    int            base0, base1;

    always #5 clk = ~clk;

    wavelet_tap_window #(.BITS_PER_ELEM(BW), .NUM_ELEM(NE), .STRIDE(1)) u_dut_s1 (
        .clk(clk), .rst(rst), .i_sample_valid(sample_valid), .i_sample(sample),
        .o_sample_ready(ready[0]), .i_flush(flush), .o_taps(taps[0]),
        .o_start_calc(start[0]), .o_fill(fill[0])
    );

    wavelet_tap_window #(.BITS_PER_ELEM(BW), .NUM_ELEM(NE), .STRIDE(3)) u_dut_s3 (
        .clk(clk), .rst(rst), .i_sample_valid(sample_valid), .i_sample(sample),
        .o_sample_ready(ready[1]), .i_flush(flush), .o_taps(taps[1]),
        .o_start_calc(start[1]), .o_fill(fill[1])
    );

    // Reference FIR stage: captures the window on the edge ending the pulse cycle.
    function automatic int fir_dot(input logic [TW-1:0] t);
        int c [NE];
        int s;
        logic signed [BW-1:0] e;
        c = '{1, -3, 7, 9, 7, -3, 1};
        s = 0;
        for (int i = 0; i < NE; i++) begin
            e = t[BW*i +: BW];
            s += c[i] * int'(e);
        end
        return s;
    endfunction

    always @(posedge clk) begin
        if (start[0]) fir_sum <= fir_dot(taps[0]);
    end

    function automatic int stride_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_win[k]   = '0;
            m_fill[k]  = 0;
            m_cnt[k]   = 0;
            m_pulse[k] = 1'b0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic model_update(input int k, input logic acc, input logic [BW-1:0] s, input logic f);
        m_pulse[k] = 1'b0;
        if (f) begin
            m_win[k]  = '0;
            m_fill[k] = 0;
            m_cnt[k]  = 0;
        end else if (acc) begin
            m_win[k] = {m_win[k][TW-BW-1:0], s};
            if (m_fill[k] < NE) begin
                m_fill[k]++;
                if (m_fill[k] == NE) begin
                    m_pulse[k] = 1'b1;
                    m_cnt[k]   = 0;
                end
            end else begin
                m_cnt[k]++;
                if (m_cnt[k] == stride_of(k)) begin
                    m_cnt[k]   = 0;
                    m_pulse[k] = 1'b1;
                end
            end
        end
        if (m_pulse[k]) begin
            if (k == 0) q0.push_back(m_win[k]);
            else        q1.push_back(m_win[k]);
        end
    endtask

    task automatic observe(input int k);
        logic [TW-1:0] exp_taps;
        int qs;
        check_value($sformatf("start[%0d]", k), 64'(start[k]), 64'(m_pulse[k]));
        check_value($sformatf("fill[%0d]", k), 64'(fill[k]), 64'(m_fill[k]));
        check_value($sformatf("taps[%0d]", k), 64'(taps[k]), 64'(m_win[k]));
        if (start[k]) begin
            qs = (k == 0) ? q0.size() : q1.size();
            check_value($sformatf("pulse_expected[%0d]", k), 64'(qs != 0), 64'd1);
            if (qs != 0) begin
                exp_taps = (k == 0) ? q0.pop_front() : q1.pop_front();
                check_value($sformatf("pulse_taps[%0d]", k), 64'(taps[k]), 64'(exp_taps));
                last_taps[k] = taps[k];
                n_pulse[k]++;
            end
        end
    endtask

    // Drive one cycle from a falling edge, observe #1 after the rising edge.
    task automatic step(input logic v, input logic [BW-1:0] s, input logic f);
        sample_valid = v;
        sample       = s;
        flush        = f;
        #1;
        for (int k = 0; k < 2; k++) begin
            check_value($sformatf("ready[%0d]", k), 64'(ready[k]), 64'(!f));
            model_update(k, v && !f, s, f);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) observe(k);
        @(negedge clk);
    endtask

    initial begin
        n_pulse   = '{0, 0};
        last_taps = '{'0, '0};
        model_reset();

        // Reset state
        #2;
        for (int k = 0; k < 2; k++) begin
            check_value("rst_taps", 64'(taps[k]), 64'd0);
            check_value("rst_fill", 64'(fill[k]), 64'd0);
            check_value("rst_start", 64'(start[k]), 64'd0);
            check_value("rst_ready", 64'(ready[k]), 64'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_value("ready_after_rst", 64'(ready[0]), 64'd1);
        @(negedge clk);

        // Ramp 1..7 then 8
        for (int i = 1; i <= 6; i++) step(1'b1, BW'(i), 1'b0);
        check_value("ramp_no_early_pulse", 64'(n_pulse[0]), 64'd0);
        step(1'b1, 8'd7, 1'b0);
        check_value("ramp_pulse7", 64'(n_pulse[0]), 64'd1);
        check_value("ramp_e0", 64'(last_taps[0][7:0]), 64'd7);
        check_value("ramp_e6", 64'(last_taps[0][55:48]), 64'd1);
        check_value("ramp_fill", 64'(fill[0]), 64'd7);
        step(1'b1, 8'd8, 1'b0);
        check_value("ramp_pulse8", 64'(n_pulse[0]), 64'd2);
        check_value("ramp8_e0", 64'(last_taps[0][7:0]), 64'd8);
        check_value("ramp8_e6", 64'(last_taps[0][55:48]), 64'd2);

        // Stride 3 over 1..13
        step(1'b0, 8'd0, 1'b1);
        base0 = n_pulse[0];
        base1 = n_pulse[1];
        for (int i = 1; i <= 13; i++) step(1'b1, BW'(i), 1'b0);
        check_value("stride3_pulses", 64'(n_pulse[1] - base1), 64'd3);
        check_value("stride3_last_e0", 64'(last_taps[1][7:0]), 64'd13);
        check_value("stride1_pulses", 64'(n_pulse[0] - base0), 64'd7);

        // Gapped valid, all -1
        step(1'b0, 8'd0, 1'b1);
        base0 = n_pulse[0];
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 8'hFF, 1'b0);
            step(1'b0, 8'h3C, 1'b0);
        end
        check_value("gap_pulses", 64'(n_pulse[0] - base0), 64'd1);
        check_value("gap_taps", 64'(last_taps[0]), 64'h00FF_FFFF_FFFF_FFFF);

        // Flush with simultaneous valid
        step(1'b1, 8'h55, 1'b1);
        check_value("flush_taps", 64'(taps[0]), 64'd0);
        check_value("flush_fill", 64'(fill[0]), 64'd0);
        base0 = n_pulse[0];
        base1 = n_pulse[1];
        for (int i = 1; i <= 6; i++) step(1'b1, BW'(i + 20), 1'b0);
        check_value("post_flush_no_pulse_s1", 64'(n_pulse[0] - base0), 64'd0);
        check_value("post_flush_no_pulse_s3", 64'(n_pulse[1] - base1), 64'd0);

        // Async reset mid-run
        for (int i = 0; i < 3; i++) step(1'b1, BW'(i + 40), 1'b0);
        check_value("pre_rst_pulse", 64'(start[0]), 64'd1);
        sample_valid = 1'b1;
        sample       = 8'h77;
        #2;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            check_value("async_taps", 64'(taps[k]), 64'd0);
            check_value("async_fill", 64'(fill[k]), 64'd0);
            check_value("async_start", 64'(start[k]), 64'd0);
            check_value("async_ready", 64'(ready[k]), 64'd0);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        base0 = n_pulse[0];
        for (int i = 1; i <= 6; i++) step(1'b1, BW'(i + 60), 1'b0);
        check_value("post_rst_no_pulse", 64'(n_pulse[0] - base0), 64'd0);
        step(1'b1, 8'd67, 1'b0);
        check_value("post_rst_pulse", 64'(n_pulse[0] - base0), 64'd1);

        // End-to-end with reference FIR: centre tap 100
        step(1'b0, 8'd0, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, (i == 3) ? 8'd100 : 8'd0, 1'b0);
        check_value("fir_pulse", 64'(start[0]), 64'd1);
        step(1'b0, 8'd0, 1'b0);
        check_value("fir_sum", 64'(fir_sum), 64'd900);

        check_value("q0_drained", 64'(q0.size()), 64'd0);
        check_value("q1_drained", 64'(q1.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_wavelet_tap_window
`default_nettype wire

// File: doc/wavelet_tap_window.md
# wavelet_tap_window

Upstream feeder for the wavelet FIR stage. Accepts a stream of signed samples over a valid/ready handshake, maintains a sliding window of the last NUM_ELEM samples packed exactly as the FIR `taps` bus, and emits a one-cycle calculation-start pulse when the window is full and the configured stride has elapsed. Its outputs connect directly to the FIR's `taps` and `i_start_calc` inputs. One instance feeds each filter in the bank.

## Interface
- BITS_PER_ELEM, 8, width of one signed sample and one tap element
- NUM_ELEM, 7, window length in samples; must be at least 2
- STRIDE, 1, accepted samples between successive start pulses once full; must be at least 1
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- i_sample_valid  in  1  upstream sample present
- i_sample  in  BITS_PER_ELEM  signed two's-complement sample
- o_sample_ready  out  1  block can accept; a transfer occurs on a rising edge with valid and ready both high
- i_flush  in  1  synchronous clear of window and counters
- o_taps  out  NUM_ELEM*BITS_PER_ELEM  window; element i at bits [BITS_PER_ELEM*i +: BITS_PER_ELEM], element 0 is the newest sample
- o_start_calc  out  1  one-cycle pulse; the window on o_taps is valid for the FIR during this cycle
- o_fill  out  $clog2(NUM_ELEM+1)  count of valid samples in the window, saturating at NUM_ELEM

## Operation
- States: FILL (o_fill < NUM_ELEM) and RUN (window full). Reset, and any flush, enter FILL.
- Accepting a sample:
  - Every element shifts up by one: element i+1 takes element i.
  - Element NUM_ELEM-1 is discarded.
  - Element 0 takes i_sample.
  - Samples pass through bit-exact; no sign extension or scaling.
- In FILL, each accept increments o_fill.
  - The accept that brings o_fill to NUM_ELEM moves the state to RUN.
  - That same accept schedules a start pulse and clears the stride counter to 0.
- In RUN:
  - Each accept increments the stride counter, range 0..STRIDE-1.
  - When the counter would reach STRIDE, it wraps to 0 and a start pulse is scheduled.
  - With STRIDE=1, every accept in RUN schedules a pulse.
- o_sample_ready is 1 except in these two cases, where it is 0:
  - while rst is high;
  - in any cycle in which i_flush is high.
- Flush:
  - One cycle of i_flush zeroes all taps, o_fill and the stride counter, and returns the state to FILL.
  - A sample presented in the same cycle is not accepted, because ready is low; flush takes priority.
  - A start pulse scheduled by the previous edge still appears in the flush cycle. Taps are then cleared at the end of that cycle, so the FIR captures the pre-flush window.
- While the window is not full, o_start_calc never asserts.
- Reset values: o_taps all zero, o_fill 0, o_start_calc 0, state FILL, stride counter 0. o_sample_ready goes to 1 in the first cycle after rst deasserts.

## Timing
- Accept-to-taps: o_taps reflects an accepted sample in the cycle following the accepting edge.
- Start pulse:
  - o_start_calc is registered and high for exactly the cycle after the accepting edge that scheduled it.
  - It is therefore coincident with the first cycle of the updated o_taps.
  - The FIR samples o_taps and i_start_calc on the next edge.
- Back-to-back:
  - With valid held high and STRIDE=1 in RUN, one pulse is produced per cycle, each paired with a new window.
  - If a new sample is accepted on the same edge on which the FIR captures, o_taps changes only after that edge, so the FIR sees a consistent window.
- Gaps: with no accept, o_taps, o_fill and the stride counter hold, and no pulse is generated.
- Async reset mid-stream clears everything immediately. No pulse appears after reset release until NUM_ELEM fresh accepts.
- Throughput: one sample per cycle. The block applies no backpressure except during flush and reset.

## Structure
- Shared package holds the FIR-bank constants used by this block and the FIR:
  - BITS_PER_ELEM and NUM_ELEM defaults;
  - a tap-element typedef, signed [BITS_PER_ELEM-1:0];
  - the state enum {FILL, RUN}.
- Single module; no sub-module needed. The shift register, fill and stride counters and pulse register are all local.

## Test plan
- Reset then ramp: NUM_ELEM=7, STRIDE=1, feed 1..7 continuously.
  - No pulse during the first 6 accepts.
  - Pulse in the cycle after the 7th accept, with element 0 = 7 and element 6 = 1; o_fill = 7.
  - Feed 8: pulse in the next cycle, element 0 = 8, element 6 = 2.
- Stride: STRIDE=3, feed 1..13 continuously.
  - Exactly 3 pulses: after samples 7, 10 and 13.
  - At the last pulse, element 0 = 13.
- Gapped valid: alternate valid 1/0 while feeding -1 (0xFF) seven times.
  - The pulse follows the 7th accept only.
  - Taps hold in idle cycles.
  - All elements read 0xFF, not sign-extended beyond 8 bits.
- Flush and simultaneous valid: after a full window, assert i_flush with valid=1 and sample 0x55.
  - Ready is 0 in that cycle and the sample is not stored.
  - Next cycle: taps all 0, o_fill 0.
  - The following 6 accepts produce no pulse.
- Async reset mid-run: assert rst between edges during continuous feed.
  - o_taps, o_fill and o_start_calc go to 0 without waiting for a clock edge.
  - After release, the first pulse appears only after 7 new accepts.
- End-to-end with FIR: drive the window with the pattern 0,0,0,100,0,0,0.
  - FIR o_sum equals 100 times the centre coefficient, one cycle after the start pulse.
